mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared single-port RAM arbiter between the fetch and MEM pipeline stages; one access in flight.
// Define MEM_ARBITER_RR_EN to replace fixed data-port priority with round-robin on simultaneous requests.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              grant, grant_d;
  logic              lat_we, lat_we_d;
  logic              ram_en_d, ram_we_d;
  logic [DATA_W-1:0] ram_addr_d, ram_wdata_d;
  logic              if_ready_d, mem_ready_d;
  logic [DATA_W-1:0] if_rdata_d, mem_rdata_d;
  logic              pick_data;

`ifdef MEM_ARBITER_RR_EN
  logic last_grant, last_grant_d;

  // On a tie, the port that lost last time wins.
  assign pick_data = mem_req & (~if_req | (last_grant == GNT_FETCH));
`else
  assign pick_data = mem_req;
`endif

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = mem_req & ~mem_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    grant_d     = grant;
    lat_we_d    = lat_we;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_rdata_d  = '0;
    mem_rdata_d = '0;
`ifdef MEM_ARBITER_RR_EN
    last_grant_d = last_grant;
`endif

    case (state)
      S_IDLE: begin
        if (if_req | mem_req) begin
          state_d     = S_ISSUE;
          grant_d     = pick_data ? GNT_DATA : GNT_FETCH;
          lat_we_d    = pick_data & mem_we;
          ram_en_d    = 1'b1;
          ram_we_d    = pick_data & mem_we;
          ram_addr_d  = pick_data ? mem_addr : if_addr;
          ram_wdata_d = pick_data ? mem_wdata : '0;
`ifdef MEM_ARBITER_RR_EN
          last_grant_d = pick_data ? GNT_DATA : GNT_FETCH;
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(MEM_LAT - 1);
      end
      S_WAIT: begin
        if (cnt == '0) begin
          // RAM data is valid now; capture it straight into the granted port's output.
          state_d = S_RESP;
          if (grant == GNT_DATA) begin
            mem_ready_d = 1'b1;
            mem_rdata_d = lat_we ? '0 : ram_rdata;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      grant     <= GNT_FETCH;
      lat_we    <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_grant <= GNT_DATA;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      grant     <= grant_d;
      lat_we    <= lat_we_d;
      ram_en    <= ram_en_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      if_ready  <= if_ready_d;
      mem_ready <= mem_ready_d;
      if_rdata  <= if_rdata_d;
      mem_rdata <= mem_rdata_d;
`ifdef MEM_ARBITER_RR_EN
      last_grant <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written write/readback sequences.
module tb_mem_arbiter;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned DATA_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, mem_req, mem_we;
  logic [DATA_W-1:0] if_addr, mem_addr, mem_wdata;
  logic [DATA_W-1:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic              if_ready, mem_ready, ram_en, ram_we, stall_if, stall_mem;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // RAM model: word-addressed, read data appears MEM_LAT cycles after the ram_en cycle.
  logic [31:0] ram [0:255];
  logic [31:0] pipe [MEM_LAT];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 16) ? 32'h8C220004 : 32'h0;
    end else if (ram_en && ram_we) begin
      ram[ram_addr[9:2]] <= ram_wdata;
    end
    pipe[0] <= (ram_en && !ram_we) ? ram[ram_addr[9:2]] : 32'hBAD0BAD0;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign ram_rdata = pipe[MEM_LAT-1];

  typedef struct {
    logic        rst, ifr;
    logic [31:0] ia;
    logic        mr, we;
    logic [31:0] ma, wd;
    logic        e_ifrdy;
    logic [31:0] e_ifd;
    logic        e_mrdy;
    logic [31:0] e_md;
    logic        e_en, e_we, e_sif, e_smem;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ifr, input logic [31:0] ia,
                     input logic mr, input logic we, input logic [31:0] ma, input logic [31:0] wd,
                     input logic ir, input logic [31:0] id, input logic mrd, input logic [31:0] md,
                     input logic en, input logic rwe, input logic sif, input logic smem);
    vec_t v;
    v.rst = r; v.ifr = ifr; v.ia = ia; v.mr = mr; v.we = we; v.ma = ma; v.wd = wd;
    v.e_ifrdy = ir; v.e_ifd = id; v.e_mrdy = mrd; v.e_md = md;
    v.e_en = en; v.e_we = rwe; v.e_sif = sif; v.e_smem = smem;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Runs one data-port access; reports the ram_en cycle, its address/data/we and the ready latency.
  task automatic run_mem(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         output int en_cyc, output logic [31:0] en_addr, output logic [31:0] en_wd,
                         output logic en_we, output int lat, output logic [31:0] rd);
    en_cyc = -1; en_addr = '0; en_wd = '0; en_we = 1'b0; lat = -1; rd = '0;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (ram_en && en_cyc < 0) begin
        en_cyc = k; en_addr = ram_addr; en_wd = ram_wdata; en_we = ram_we;
      end
      if (mem_ready) begin lat = k; rd = mem_rdata; end
      @(posedge clk); #1;
      mem_addr = 32'h7FC; mem_wdata = 32'h0;
      if (lat >= 0) mem_req = 1'b0;
    end
    mem_req = 1'b0;
  endtask

  localparam logic [31:0] A  = 32'h40;
  localparam logic [31:0] B  = 32'h100;
  localparam logic [31:0] C  = 32'h200;
  localparam logic [31:0] IW = 32'h8C220004;
  localparam logic [31:0] DW = 32'hDEADBEEF;

  initial begin
    int          en_cyc, lat;
    logic [31:0] en_addr, en_wd, rd;
    logic        en_we;
    logic [69:0] got, want;

    rst = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;

    // Fetch-only read of 0x40, then release.
    add(0,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   1,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,A,0,0,0,0,  1,IW,0,0,  0,0,0,0);
    add(0,0,0,0,0,0,0,  0,0,0,0,   0,0,0,0);
    // Data write then back-to-back read of 0x100.
    add(0,0,0,1,1,B,DW, 0,0,0,0,   0,0,0,1);
    add(0,0,0,1,1,B,DW, 0,0,0,0,   1,1,0,1);
    add(0,0,0,1,1,B,DW, 0,0,0,0,   0,0,0,1);
    add(0,0,0,1,1,B,DW, 0,0,0,0,   0,0,0,1);
    add(0,0,0,1,1,B,DW, 0,0,1,0,   0,0,0,0);
    add(0,0,0,1,0,B,0,  0,0,0,0,   0,0,0,1);
    add(0,0,0,1,0,B,0,  0,0,0,0,   1,0,0,1);
    add(0,0,0,1,0,B,0,  0,0,0,0,   0,0,0,1);
    add(0,0,0,1,0,B,0,  0,0,0,0,   0,0,0,1);
    add(0,0,0,1,0,B,0,  0,0,1,DW,  0,0,0,0);
    add(0,0,0,0,0,0,0,  0,0,0,0,   0,0,0,0);
    // Simultaneous requests.
    add(0,1,A,1,0,B,0,  0,0,0,0,   0,0,1,1);
    add(0,1,A,1,0,B,0,  0,0,0,0,   1,0,1,1);
    add(0,1,A,1,0,B,0,  0,0,0,0,   0,0,1,1);
    add(0,1,A,1,0,B,0,  0,0,0,0,   0,0,1,1);
`ifdef MEM_ARBITER_RR_EN
    add(0,1,A,1,0,B,0,  1,IW,0,0,  0,0,0,1);
    add(0,0,0,1,0,B,0,  0,0,0,0,   0,0,0,1);
    add(0,0,0,1,0,B,0,  0,0,0,0,   1,0,0,1);
    add(0,0,0,1,0,B,0,  0,0,0,0,   0,0,0,1);
    add(0,0,0,1,0,B,0,  0,0,0,0,   0,0,0,1);
    add(0,0,0,1,0,B,0,  0,0,1,DW,  0,0,0,0);
`else
    add(0,1,A,1,0,B,0,  0,0,1,DW,  0,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   1,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,A,0,0,0,0,  1,IW,0,0,  0,0,0,0);
`endif
    add(0,0,0,0,0,0,0,  0,0,0,0,   0,0,0,0);
    // Fetch flushed in cycle 2 with an address change after accept; data read in cycle 5.
    add(0,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,B,0,0,0,0,  0,0,0,0,   1,0,1,0);
    add(0,0,0,0,0,0,0,  0,0,0,0,   0,0,0,0);
    add(0,0,0,0,0,0,0,  0,0,0,0,   0,0,0,0);
    add(0,0,0,0,0,0,0,  1,IW,0,0,  0,0,0,0);
    add(0,0,0,1,0,A,0,  0,0,0,0,   0,0,0,1);
    add(0,0,0,1,0,C,5,  0,0,0,0,   1,0,0,1);
    add(0,0,0,1,0,C,5,  0,0,0,0,   0,0,0,1);
    add(0,0,0,1,0,C,5,  0,0,0,0,   0,0,0,1);
    add(0,0,0,1,0,C,5,  0,0,1,IW,  0,0,0,0);
    add(0,0,0,0,0,0,0,  0,0,0,0,   0,0,0,0);
    // Reset in IDLE must not accept a pending request.
    add(1,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,0,0,0,0,0,0,  0,0,0,0,   0,0,0,0);
    // Reset during WAIT abandons the fetch; the requeued fetch completes.
    add(0,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   1,0,1,0);
    add(1,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   1,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,A,0,0,0,0,  0,0,0,0,   0,0,1,0);
    add(0,1,A,0,0,0,0,  1,IW,0,0,  0,0,0,0);
    add(0,0,0,0,0,0,0,  0,0,0,0,   0,0,0,0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; if_req = vecs[i].ifr; if_addr = vecs[i].ia;
      mem_req = vecs[i].mr; mem_we = vecs[i].we; mem_addr = vecs[i].ma; mem_wdata = vecs[i].wd;
      @(negedge clk);
      got  = {if_ready, if_rdata, mem_ready, mem_rdata, ram_en, ram_we, stall_if, stall_mem};
      want = {vecs[i].e_ifrdy, vecs[i].e_ifd, vecs[i].e_mrdy, vecs[i].e_md,
              vecs[i].e_en, vecs[i].e_we, vecs[i].e_sif, vecs[i].e_smem};
      chk($sformatf("vec%0d", i), 128'(got), 128'(want));
    end

    // Write with inputs changed after accept: RAM strobe must carry the accepted values.
    run_mem(1'b1, 32'h3C, 32'h12345678, en_cyc, en_addr, en_wd, en_we, lat, rd);
    chk("wr_en_cycle", 128'(en_cyc), 128'(1));
    chk("wr_ram_addr", 128'(en_addr), 128'(32'h3C));
    chk("wr_ram_wdata", 128'(en_wd), 128'(32'h12345678));
    chk("wr_ram_we", 128'(en_we), 128'(1));
    chk("wr_latency", 128'(lat), 128'(MEM_LAT + 2));
    chk("wr_rdata", 128'(rd), 128'(0));

    run_mem(1'b0, 32'h3C, 32'hFFFFFFFF, en_cyc, en_addr, en_wd, en_we, lat, rd);
    chk("rd_ram_addr", 128'(en_addr), 128'(32'h3C));
    chk("rd_ram_we", 128'(en_we), 128'(0));
    chk("rd_latency", 128'(lat), 128'(MEM_LAT + 2));
    chk("rd_rdata", 128'(rd), 128'(32'h12345678));
    @(negedge clk);
    chk("if_rdata_idle", 128'(if_rdata), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
